// File: rtl/risac_lsu_mem_bridge.sv
// Load/store bridge from the risac data port to single-port on-chip memory.
// Optional macro LSU_MISALIGN_ERR_EN: misaligned half/word requests return an error instead of being aligned down.
module risac_lsu_mem_bridge #(
  parameter int ADDR_W     = 12,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-3:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  output logic              mem_clken,
  input  logic [31:0]       mem_readdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

`ifdef LSU_MISALIGN_ERR_EN
  localparam logic MISALIGN_ERR = 1'b1;
`else
  localparam logic MISALIGN_ERR = 1'b0;
`endif

  function automatic logic is_illegal(input logic [1:0] size, input logic [1:0] a);
    return (size == 2'b11) ||
           (MISALIGN_ERR && (((size == 2'b01) && a[0]) || ((size == 2'b10) && (a != 2'b00))));
  endfunction

  // Legal aligned offsets pass through unchanged, so this is harmless when errors are enabled.
  function automatic logic [1:0] align_offset(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   return a;
      2'b01:   return {a[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   return 4'b0001 << a;
      2'b01:   return 4'b0011 << {a[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] rd, input logic [1:0] size,
                                              input logic uns, input logic [1:0] a);
    logic [31:0]        s;
    logic signed [7:0]  b8;
    logic signed [15:0] h16;
    logic signed [31:0] sx;
    s   = rd;
    b8  = '0;
    h16 = '0;
    sx  = signed'(rd);
    case (size)
      2'b00: begin
        s  = rd >> {a, 3'b000};
        b8 = signed'(s[7:0]);
        sx = uns ? signed'({24'd0, s[7:0]}) : 32'(b8);
      end
      2'b01: begin
        s   = rd >> {a[1], 4'b0000};
        h16 = signed'(s[15:0]);
        sx  = uns ? signed'({16'd0, s[15:0]}) : 32'(h16);
      end
      default: sx = signed'(rd);
    endcase
    return unsigned'(sx);
  endfunction

  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              cs_q, cs_d, we_q, we_d;
  logic [ADDR_W-3:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wd_q, wd_d, rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [1:0]        size_q, size_d, off_q, off_d;
  logic              uns_q, uns_d;
  logic [1:0]        off_req;

  assign off_req = align_offset(req_size, req_addr[1:0]);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cs_d    = 1'b0;
    we_d    = 1'b0;
    addr_d  = addr_q;
    be_d    = be_q;
    wd_d    = wd_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    size_d  = size_q;
    off_d   = off_q;
    uns_d   = uns_q;
    case (state_q)
      IDLE: if (req_valid) begin
        rdata_d = '0;
        if (is_illegal(req_size, req_addr[1:0])) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          err_d   = 1'b0;
          cs_d    = 1'b1;
          we_d    = req_write;
          addr_d  = req_addr[ADDR_W-1:2];
          be_d    = lane_be(req_size, off_req);
          wd_d    = lane_wdata(req_size, req_wdata);
          size_d  = req_size;
          off_d   = off_req;
          uns_d   = req_unsigned;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        cnt_d   = 2'(RD_LATENCY - 1);
        state_d = we_q ? RESP : WAIT;
      end
      WAIT: begin
        if (cnt_q == 2'd0) begin
          rdata_d = load_extend(mem_readdata, size_q, uns_q, off_q);
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control and every output-facing register: cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cs_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wd_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cs_q    <= cs_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wd_q    <= wd_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Load-format context, only consumed after being captured at acceptance.
  always_ff @(posedge clk) begin
    size_q <= size_d;
    off_q  <= off_d;
    uns_q  <= uns_d;
  end

  assign req_ready      = (state_q == IDLE);
  assign rsp_valid      = (state_q == RESP);
  assign rsp_rdata      = rdata_q;
  assign rsp_err        = err_q;
  assign mem_address    = addr_q;
  assign mem_byteenable = be_q;
  assign mem_chipselect = cs_q;
  assign mem_write      = we_q;
  assign mem_writedata  = wd_q;
  assign mem_clken      = ~reset;

endmodule

// File: tb/tb_risac_lsu_mem_bridge.sv
// Self-checking bench for risac_lsu_mem_bridge with a behavioural memory of latency L.
module tb_risac_lsu_mem_bridge;
  localparam int L = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0, req_unsigned = 1'b0, rsp_ready = 1'b0;
  logic [1:0]  req_size = 2'b10;
  logic [11:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_err, mem_chipselect, mem_write, mem_clken;
  logic [31:0] rsp_rdata, mem_writedata, mem_readdata;
  logic [9:0]  mem_address;
  logic [3:0]  mem_byteenable;

  risac_lsu_mem_bridge #(.ADDR_W(12), .RD_LATENCY(L)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
  );

  always #5 clk = ~clk;

  // Memory model: bytes written under byteenable, read data delayed L cycles after the strobe.
  logic [31:0] mem [0:1023];
  logic [31:0] rd_pipe [0:L-1];
  int          stb_cnt = 0;
  logic [9:0]  stb_addr;
  logic [3:0]  stb_be;
  logic [31:0] stb_wd;

  always @(posedge clk) begin
    if (mem_chipselect && mem_write)
      for (int i = 0; i < 4; i++)
        if (mem_byteenable[i]) mem[mem_address][8*i +: 8] <= mem_writedata[8*i +: 8];
    rd_pipe[0] <= (mem_chipselect && !mem_write) ? mem[mem_address] : 32'hBAD0_BAD0;
    for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
    if (mem_chipselect) begin
      stb_cnt  <= stb_cnt + 1;
      stb_addr <= mem_address;
      stb_be   <= mem_byteenable;
      stb_wd   <= mem_writedata;
    end
  end
  assign mem_readdata = rd_pipe[L-1];

  typedef struct {
    logic [31:0] rd;
    logic        err;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic        uns;
    logic [11:0] ad;
    logic [31:0] wd;
    logic [31:0] erd;
    logic        eerr;
    int          enstb;
    logic [9:0]  ea;
    logic [3:0]  ebe;
    logic [31:0] ewd;
    string       name;
  } txn_t;

  int errors = 0;
  int checks = 0;

  // Drive one request starting at a negedge; returns at the negedge after acceptance.
  task automatic send(input logic wr, input logic [1:0] sz, input logic uns,
                      input logic [11:0] ad, input logic [31:0] wd);
    int n = 0;
    req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
    req_addr = ad; req_wdata = wd;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (!req_ready) begin
      errors++; checks++;
      $display("FAIL send_timeout: req_ready=%b after %0d cycles, required 1", req_ready, n);
    end
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic get_rsp(output bit ok, output logic [31:0] rd, output logic e);
    int n = 0;
    rsp_ready = 1'b1;
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    ok = rsp_valid; rd = rsp_rdata; e = rsp_err;
    @(posedge clk); @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic do_txn(input txn_t t, output bit ok, output logic [31:0] rd, output logic e,
                        output int nstb);
    int c0 = stb_cnt;
    sb.push_back('{t.erd, t.eerr});
    send(t.wr, t.sz, t.uns, t.ad, t.wd);
    get_rsp(ok, rd, e);
    nstb = stb_cnt - c0;
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, rsp_err, mem_chipselect, mem_write, mem_clken, mem_byteenable} !== 10'b1000000000) begin
      errors++;
      $display("FAIL reset_ctrl: ready=%b rvalid=%b err=%b cs=%b we=%b clken=%b be=%b, required 1 0 0 0 0 0 0000",
               req_ready, rsp_valid, rsp_err, mem_chipselect, mem_write, mem_clken, mem_byteenable);
    end
    checks++;
    if ({rsp_rdata, mem_writedata, mem_address} !== 74'd0) begin
      errors++;
      $display("FAIL reset_data: rdata=%h wdata=%h addr=%h, required all zero", rsp_rdata, mem_writedata, mem_address);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (mem_clken !== 1'b1) begin
      errors++; $display("FAIL clken_release: mem_clken=%b, required 1", mem_clken);
    end
    @(negedge clk);
  endtask

  task automatic run_table(input txn_t t);
    bit ok; logic [31:0] rd; logic e; int nstb; exp_t x;
    do_txn(t, ok, rd, e, nstb);
    x = sb.pop_front();
    checks++;
    if (!ok || rd !== x.rd || e !== x.err) begin
      errors++;
      $display("FAIL %s_rsp: valid=%b rdata=%h err=%b, required rdata=%h err=%b", t.name, ok, rd, e, x.rd, x.err);
    end
    checks++;
    if (nstb !== t.enstb || (nstb == 1 && (stb_addr !== t.ea || stb_be !== t.ebe || (t.wr && stb_wd !== t.ewd)))) begin
      errors++;
      $display("FAIL %s_strobe: pulses=%0d addr=%h be=%b wdata=%h, required pulses=%0d addr=%h be=%b wdata=%h",
               t.name, nstb, stb_addr, stb_be, stb_wd, t.enstb, t.ea, t.ebe, t.ewd);
    end
  endtask

  task automatic test_word();
    run_table('{1'b1, 2'b10, 1'b0, 12'h010, 32'hDEADBEEF, 32'h0, 1'b0, 1, 10'h004, 4'hF, 32'hDEADBEEF, "st_word"});
    run_table('{1'b0, 2'b10, 1'b0, 12'h010, 32'h0, 32'hDEADBEEF, 1'b0, 1, 10'h004, 4'hF, 32'h0, "ld_word"});
  endtask

  task automatic test_byte();
    run_table('{1'b1, 2'b00, 1'b0, 12'h013, 32'h12345680, 32'h0, 1'b0, 1, 10'h004, 4'b1000, 32'h80808080, "st_byte"});
    run_table('{1'b0, 2'b00, 1'b0, 12'h013, 32'h0, 32'hFFFFFF80, 1'b0, 1, 10'h004, 4'b1000, 32'h0, "ld_byte_s"});
    run_table('{1'b0, 2'b00, 1'b1, 12'h013, 32'h0, 32'h00000080, 1'b0, 1, 10'h004, 4'b1000, 32'h0, "ld_byte_u"});
    run_table('{1'b0, 2'b00, 1'b1, 12'h011, 32'h0, 32'h000000BE, 1'b0, 1, 10'h004, 4'b0010, 32'h0, "ld_byte1_u"});
  endtask

  task automatic test_half();
    run_table('{1'b1, 2'b10, 1'b0, 12'h010, 32'h80011234, 32'h0, 1'b0, 1, 10'h004, 4'hF, 32'h80011234, "st_w4"});
    run_table('{1'b0, 2'b01, 1'b0, 12'h012, 32'h0, 32'hFFFF8001, 1'b0, 1, 10'h004, 4'b1100, 32'h0, "ld_half_s"});
    run_table('{1'b0, 2'b01, 1'b1, 12'h012, 32'h0, 32'h00008001, 1'b0, 1, 10'h004, 4'b1100, 32'h0, "ld_half_u"});
    run_table('{1'b0, 2'b01, 1'b0, 12'h010, 32'h0, 32'h00001234, 1'b0, 1, 10'h004, 4'b0011, 32'h0, "ld_half_lo"});
    run_table('{1'b1, 2'b10, 1'b0, 12'h020, 32'h11111111, 32'h0, 1'b0, 1, 10'h008, 4'hF, 32'h11111111, "st_w8"});
    run_table('{1'b1, 2'b01, 1'b0, 12'h022, 32'h0000A5C3, 32'h0, 1'b0, 1, 10'h008, 4'b1100, 32'hA5C3A5C3, "st_half"});
    run_table('{1'b0, 2'b10, 1'b0, 12'h020, 32'h0, 32'hA5C31111, 1'b0, 1, 10'h008, 4'hF, 32'h0, "ld_w8"});
  endtask

  task automatic test_misalign();
    run_table('{1'b1, 2'b10, 1'b0, 12'h004, 32'h12345678, 32'h0, 1'b0, 1, 10'h001, 4'hF, 32'h12345678, "st_w1"});
`ifdef LSU_MISALIGN_ERR_EN
    run_table('{1'b0, 2'b10, 1'b0, 12'h006, 32'h0, 32'h0, 1'b1, 0, 10'h0, 4'h0, 32'h0, "ld_word_mis"});
    run_table('{1'b0, 2'b01, 1'b0, 12'h011, 32'h0, 32'h0, 1'b1, 0, 10'h0, 4'h0, 32'h0, "ld_half_mis"});
`else
    run_table('{1'b0, 2'b10, 1'b0, 12'h006, 32'h0, 32'h12345678, 1'b0, 1, 10'h001, 4'hF, 32'h0, "ld_word_mis"});
    run_table('{1'b0, 2'b01, 1'b0, 12'h011, 32'h0, 32'h00001234, 1'b0, 1, 10'h004, 4'b0011, 32'h0, "ld_half_mis"});
`endif
  endtask

  task automatic test_illegal_hold();
    bit ok; logic [31:0] rd; logic e; int c0; exp_t x;
    c0 = stb_cnt;
    sb.push_back('{32'h0, 1'b1});
    send(1'b0, 2'b11, 1'b0, 12'h010, 32'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({rsp_valid, rsp_err, req_ready} !== 3'b110 || rsp_rdata !== 32'h0) begin
        errors++;
        $display("FAIL illegal_hold[%0d]: valid=%b err=%b ready=%b rdata=%h, required 1 1 0 00000000",
                 i, rsp_valid, rsp_err, req_ready, rsp_rdata);
      end
    end
    get_rsp(ok, rd, e);
    x = sb.pop_front();
    checks++;
    if (!ok || rd !== x.rd || e !== x.err || stb_cnt != c0) begin
      errors++;
      $display("FAIL illegal_rsp: valid=%b rdata=%h err=%b pulses=%0d, required rdata=%h err=%b pulses=0",
               ok, rd, e, stb_cnt - c0, x.rd, x.err);
    end
  endtask

  task automatic test_reset_wait();
    int c0; bit seen = 0;
    c0 = stb_cnt;
    send(1'b0, 2'b10, 1'b0, 12'h010, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if ({req_ready, rsp_valid, mem_chipselect, mem_clken, mem_byteenable} !== 8'b10000000 ||
        {rsp_rdata, mem_address, mem_writedata} !== 74'd0) begin
      errors++;
      $display("FAIL reset_wait_async: ready=%b rvalid=%b cs=%b clken=%b be=%b addr=%h, required 1 0 0 0 0000 000",
               req_ready, rsp_valid, mem_chipselect, mem_clken, mem_byteenable, mem_address);
    end
    @(negedge clk);
    reset = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid || mem_chipselect) seen = 1;
    end
    rsp_ready = 1'b0;
    checks++;
    if (seen || stb_cnt - c0 != 1) begin
      errors++;
      $display("FAIL reset_wait_abandon: late activity=%b pulses=%0d, required 0 and 1", seen, stb_cnt - c0);
    end
    run_table('{1'b0, 2'b10, 1'b0, 12'h010, 32'h0, 32'h80011234, 1'b0, 1, 10'h004, 4'hF, 32'h0, "ld_after_rst"});
  endtask

  task automatic test_back_to_back();
    int t[3];
    for (int pass = 0; pass < 2; pass++) begin
      int k = 0;
      int cyc = 0;
      rsp_ready = 1'b1;
      req_valid = 1'b1; req_write = (pass == 0); req_size = 2'b10; req_addr = 12'h030;
      req_wdata = 32'hCAFE0000 + pass;
      while (k < 3 && cyc < 60) begin
        if (req_ready) begin t[k] = cyc; k++; end
        if (k == 3) req_valid = 1'b0;
        @(negedge clk);
        cyc++;
      end
      req_valid = 1'b0;
      for (int i = 0; i < 10; i++) @(negedge clk);
      rsp_ready = 1'b0;
      checks++;
      if (k != 3 || t[1] - t[0] != (pass == 0 ? 3 : 3 + L) || t[2] - t[1] != (pass == 0 ? 3 : 3 + L)) begin
        errors++;
        $display("FAIL turnaround_%s: accepts=%0d gaps=%0d,%0d, required 3 accepts with gap %0d",
                 pass == 0 ? "store" : "load", k, t[1] - t[0], t[2] - t[1], pass == 0 ? 3 : 3 + L);
      end
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_misalign();
    test_illegal_hold();
    test_reset_wait();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
